rk_spi_master: RTL and testbench
================================

# rk_spi_master

Parametrised hardware SPI master that replaces the bit-banged SD card port of the Radio-86RK top level. Sits on the CPU data bus at the former SD window (A15:A13 = 101). Provides a byte shifter with programmable clock divider, multiple chip selects and selectable SPI mode, so the BIOS moves one byte per bus write instead of one bit per access.

## Interface
Parameters:
- CS_COUNT, 1: number of chip-select outputs (1..8).
- DIV_WIDTH, 8: width of the clock divider register (1..8).
- DIV_RESET, 8'd63: divider value after reset; SCLK half-period = DIV+1 clk cycles (≈390 kHz at 50 MHz, SD-init safe).

Ports:
- clk, in, 1: system clock (clk50mhz domain).
- reset_n, in, 1: asynchronous, active-low reset.
- iaddr, in, 2: register select.
- idata, in, 8: CPU write data.
- iwe_n, in, 1: write strobe, active low, may stay low many cycles.
- ird_n, in, 1: read strobe, active low.
- odata, out, 8: register read data (combinational from iaddr).
- sclk, out, 1: SPI clock.
- mosi, out, 1: SPI data out.
- miso, in, 1: SPI data in.
- cs_n, out, CS_COUNT: chip selects, active low.
- busy, out, 1: transfer in progress.
- irq, out, 1: equals DONE flag.

## Operation
- Strobe qualification: an access acts once, on the first clk where iwe_n (ird_n) is 0 after having been 1 (falling-edge detect with one registered stage).
- Reg 0 DATA: write while idle loads tx shifter, clears DONE, starts transfer. Write while busy is dropped, sets OVR. Read returns last rx byte; read edge clears DONE.
- Reg 1 CTRL/STATUS: read {busy, OVR, DONE, 3'b000, CPHA, CPOL}. Write bit 6 = 1 clears OVR and DONE. Bits 1:0 load CPOL/CPHA only when idle; ignored while busy.
- Reg 2 CS: bits [CS_COUNT-1:0] select (1 = asserted); cs_n = ~reg. Upper bits read 0. Writable while busy (no transfer abort).
- Reg 3 DIV: low DIV_WIDTH bits; write ignored while busy; upper bits read 0.
- FSM: IDLE -> SHIFT (16 half-periods, counter 0..15) -> IDLE. Half-period timer counts DIV..0, reloads.
- Leading edge (even half index end) / trailing edge (odd): CPHA=0 samples miso on leading, shifts mosi on trailing; CPHA=1 shifts on leading, samples on trailing. MSB first.
- sclk idles at CPOL; toggles at each half-period end.
- mosi holds last driven bit when idle; 1 after reset.
- rx byte latched into DATA read register at end of 16th half-period; DONE set same cycle busy falls.
- reset_n low mid-transfer: FSM to IDLE immediately, shifter lost, all outputs to reset values.

## Timing
- Reset values: sclk=0, mosi=1, cs_n=all 1, busy=0, irq=0, odata per iaddr with rx=8'hFF, DIV=DIV_RESET, CPOL=CPHA=0.
- Write edge at cycle T: busy=1 at T+1; CPHA=0 first mosi bit valid at T+1.
- Transfer length: 16×(DIV+1) cycles from busy rise to busy fall.
- DIV=0: sclk = clk/2; DIV max = 2^DIV_WIDTH−1.
- Back-to-back: write accepted in cycle busy first reads 0.
- Simultaneous DONE set and DATA-read clear: set wins.
- Simultaneous OVR set and CTRL bit-6 clear: set wins.

## Configuration
- SPI_MODE_SEL_EN defined: CPOL/CPHA writable, all four SPI modes.
- Undefined: mode 0 fixed; CTRL bits 1:0 read 0, writes ignored; CPHA=1 logic absent.

## Test plan
- Reset release: cs_n=all 1, sclk=0, mosi=1, CTRL reads 8'h00, DIV reads DIV_RESET.
- DIV=0, mode 0, miso loopback to mosi, write 8'hA5 -> mosi A5 MSB first, 8 sclk pulses, busy 16 cycles, DATA reads 8'hA5, irq=1, irq 0 after DATA read.
- DIV=3, CTRL 8'h03, miso tied 0, write 8'h3C -> sclk idles 1, half-period 4 cycles, 64-cycle transfer, DATA reads 8'h00 (macro off: CTRL reads 8'h00, mode 0 waveform).
- Write 8'h11 then 8'h22 while busy -> only 8'h11 shifted, CTRL reads bit 6 set; write CTRL 8'h40 -> OVR and DONE clear.
- CS_COUNT=4, write CS 8'hF5 -> cs_n=4'b1010, CS reads 8'h05; iwe_n held low 30 cycles -> single action.
- reset_n low at half-period 7 of a transfer -> busy=0, sclk=0, mosi=1 asynchronously; next transfer after release completes normally.

Source files
------------

// File: rtl/rk_spi_master.sv
// rk_spi_master: byte-wide SPI master on the CPU bus.
// Four registers: DATA, CTRL/STATUS, CS and DIV. The clock divider and the
// chip-select count are parameters.
// Optional feature macro: SPI_MODE_SEL_EN. When it is defined, CPOL and CPHA
// are writable and all four SPI modes are available. When it is undefined,
// the block is fixed to mode 0.
module rk_spi_master #(
  parameter int         CS_COUNT  = 1,
  parameter int         DIV_WIDTH = 8,
  parameter logic [7:0] DIV_RESET = 8'd63
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          iaddr,
  input  logic [7:0]          idata,
  input  logic                iwe_n,
  input  logic                ird_n,
  output logic [7:0]          odata,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [CS_COUNT-1:0] cs_n,
  output logic                busy,
  output logic                irq
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_we_d, r_rd_d;
  logic [DIV_WIDTH-1:0]   r_tmr, r_div;
  logic [3:0]             r_half;
  logic [7:0]             r_txsh, r_rxsh, r_rx;
  logic                   r_mosi, r_sclk, r_done, r_ovr;
  logic [CS_COUNT-1:0]    r_cs;
  logic                   w_cpol, w_cpha;
  logic                   w_wr, w_rd, w_idle, w_start;
  logic                   w_wr_data, w_wr_ctrl, w_wr_cs, w_wr_div;
  logic                   w_half_end, w_last, w_lead, w_trail;
  logic                   w_sample, w_shift;
  logic [7:0]             w_rx_nxt, w_cs8, w_div8;

  // An access acts only on the first cycle its strobe is seen low.
  assign w_wr      = ~iwe_n & r_we_d;
  assign w_rd      = ~ird_n & r_rd_d;
  assign w_wr_data = w_wr & (iaddr == 2'd0);
  assign w_wr_ctrl = w_wr & (iaddr == 2'd1);
  assign w_wr_cs   = w_wr & (iaddr == 2'd2);
  assign w_wr_div  = w_wr & (iaddr == 2'd3);
  assign w_idle    = (r_state == S_IDLE);
  assign w_start   = w_wr_data & w_idle;

  // A half period ends when the timer reaches 0. Even indices are the leading edge.
  assign w_half_end = (r_state == S_SHIFT) && (r_tmr == '0);
  assign w_last     = w_half_end && (r_half == 4'd15);
  assign w_lead     = w_half_end & ~r_half[0];
  assign w_trail    = w_half_end &  r_half[0];

`ifdef SPI_MODE_SEL_EN
  logic r_cpol, r_cpha;

  // Mode bits load only between transfers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
    end else if (w_wr_ctrl && w_idle) begin
      r_cpha <= idata[1];
      r_cpol <= idata[0];
    end
  end

  assign w_cpol   = r_cpol;
  assign w_cpha   = r_cpha;
  assign w_sample = r_cpha ? w_trail : w_lead;
  // In mode 0 the first bit is preloaded at start, so the final trailing edge must not shift.
  assign w_shift  = r_cpha ? w_lead : (w_trail & ~w_last);
`else
  assign w_cpol   = 1'b0;
  assign w_cpha   = 1'b0;
  assign w_sample = w_lead;
  assign w_shift  = w_trail & ~w_last;
`endif

  // The receive byte includes the bit sampled on the final edge.
  assign w_rx_nxt = w_sample ? {r_rxsh[6:0], miso} : r_rxsh;

  // Strobe history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we_d <= 1'b1;
      r_rd_d <= 1'b1;
    end else begin
      r_we_d <= iwe_n;
      r_rd_d <= ird_n;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: a DATA write starts a transfer, and the 16th half period ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Half-period timer counts DIV..0 and steps the half index on reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmr  <= '0;
      r_half <= '0;
    end else if (w_start) begin
      r_tmr  <= r_div;
      r_half <= '0;
    end else if (r_state == S_SHIFT) begin
      if (r_tmr == '0) begin
        r_tmr  <= r_div;
        r_half <= r_half + 4'd1;
      end else begin
        r_tmr  <= r_tmr - 1'b1;
      end
    end
  end

  // Shift registers and SPI pins.
  // In mode 0, MSB goes out at start and the shifter keeps the remaining bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_txsh <= '0;
      r_rxsh <= '0;
      r_rx   <= 8'hFF;
      r_mosi <= 1'b1;
      r_sclk <= 1'b0;
    end else begin
      r_rxsh <= w_rx_nxt;
      if (w_start) begin
        if (w_cpha) begin
          r_txsh <= idata;
        end else begin
          r_txsh <= {idata[6:0], 1'b0};
          r_mosi <= idata[7];
        end
      end else if (w_shift) begin
        r_mosi <= r_txsh[7];
        r_txsh <= {r_txsh[6:0], 1'b0};
      end
      if (w_last) r_rx <= w_rx_nxt;
      if (w_half_end)  r_sclk <= ~r_sclk;
      else if (w_idle) r_sclk <= w_cpol;
    end
  end

  // DONE and OVR flags. When a set and a clear coincide, the set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_last)
        r_done <= 1'b1;
      else if (w_start || (w_wr_ctrl && idata[6]) || (w_rd && iaddr == 2'd0))
        r_done <= 1'b0;
      if (w_wr_data && !w_idle)
        r_ovr <= 1'b1;
      else if (w_wr_ctrl && idata[6])
        r_ovr <= 1'b0;
    end
  end

  // CS can be written at any time. DIV is frozen during a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs  <= '0;
      r_div <= DIV_RESET[DIV_WIDTH-1:0];
    end else begin
      if (w_wr_cs)             r_cs  <= idata[CS_COUNT-1:0];
      if (w_wr_div && w_idle)  r_div <= idata[DIV_WIDTH-1:0];
    end
  end

  // Register read mux. It is combinational from iaddr, and unused upper bits read 0.
  always_comb begin
    w_cs8                 = '0;
    w_cs8[CS_COUNT-1:0]   = r_cs;
    w_div8                = '0;
    w_div8[DIV_WIDTH-1:0] = r_div;
    case (iaddr)
      2'd0:    odata = r_rx;
      2'd1:    odata = {~w_idle, r_ovr, r_done, 3'b000, w_cpha, w_cpol};
      2'd2:    odata = w_cs8;
      default: odata = w_div8;
    endcase
  end

  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs_n = ~r_cs;
  assign busy = ~w_idle;
  assign irq  = r_done;

endmodule

// File: tb/tb_rk_spi_master.sv
// Self-checking bench for rk_spi_master (CS_COUNT=4, DIV_WIDTH=8, DIV_RESET=63).
// The reference model derives the expected sclk, mosi and rx values from
// the half-period index and the SPI mode.
module tb_rk_spi_master;

`ifdef SPI_MODE_SEL_EN
  localparam bit MODE_EN = 1'b1;
`else
  localparam bit MODE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] iaddr;
  logic [7:0] idata;
  logic       iwe_n, ird_n;
  logic [7:0] odata;
  logic       sclk, mosi, miso;
  logic [3:0] cs_n;
  logic       busy, irq;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         cur_div;
  logic       cur_cpol, cur_cpha, last_mosi, m_done, m_ovr;

  rk_spi_master #(.CS_COUNT(4), .DIV_WIDTH(8), .DIV_RESET(8'd63)) dut (
    .clk(clk), .reset_n(reset_n), .iaddr(iaddr), .idata(idata),
    .iwe_n(iwe_n), .ird_n(ird_n), .odata(odata), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] exp_ctrl(input logic b);
    return {b, m_ovr, m_done, 3'b000, cur_cpha, cur_cpol};
  endfunction

  task automatic model_reset();
    cur_div = 63; cur_cpol = 1'b0; cur_cpha = 1'b0;
    last_mosi = 1'b1; m_done = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  // single register write while idle; updates the model as the register map dictates
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iaddr = a; idata = d; iwe_n = 1'b0;
    step();
    iwe_n = 1'b1;
    step();
    case (a)
      2'd1: begin
        if (d[6]) begin m_ovr = 1'b0; m_done = 1'b0; end
        if (MODE_EN) begin cur_cpha = d[1]; cur_cpol = d[0]; end
      end
      2'd3: cur_div = int'(d);
      default: ;
    endcase
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] v);
    iaddr = a; #1; v = odata;
  endtask

  task automatic rd_data();
    iaddr = 2'd0; ird_n = 1'b0;
    step();
    ird_n = 1'b1;
    step();
    m_done = 1'b0;
  endtask

  // Runs one transfer and checks every cycle against the half-period model.
  // ovr_at >= 0 adds a second DATA write during that busy cycle.
  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] rxb,
                         input bit loopback, input int ovr_at);
    int n, h, j;
    logic es, em;
    logic [7:0] v, exp_rx;
    n = 16 * (cur_div + 1);
    exp_rx = loopback ? tx : rxb;
    iaddr = 2'd0; idata = tx; iwe_n = 1'b0;
    step();
    iwe_n = 1'b1;
    m_done = 1'b0;
    if (ovr_at >= 0) m_ovr = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == ovr_at) begin iwe_n = 1'b0; idata = tx ^ 8'h33; end
      if (k == ovr_at + 1) iwe_n = 1'b1;
      h  = k / (cur_div + 1);
      es = cur_cpol ^ h[0];
      if (!cur_cpha) em = tx[7 - h/2];
      else           em = (h == 0) ? last_mosi : tx[7 - (h-1)/2];
      j = cur_cpha ? ((h == 0) ? 0 : (h-1)/2) : h/2;
      miso = loopback ? em : rxb[7 - j];
      checks += 3;
      if (busy !== 1'b1) begin errors++; $display("FAIL xfer_busy cyc %0d got %b exp 1", k, busy); end
      if (sclk !== es)   begin errors++; $display("FAIL xfer_sclk cyc %0d got %b exp %b", k, sclk, es); end
      if (mosi !== em)   begin errors++; $display("FAIL xfer_mosi cyc %0d got %b exp %b", k, mosi, em); end
      step();
    end
    m_done = 1'b1;
    last_mosi = tx[0];
    checks += 5;
    if (busy !== 1'b0)     begin errors++; $display("FAIL xfer_end_busy got %b exp 0", busy); end
    if (irq !== 1'b1)      begin errors++; $display("FAIL xfer_irq got %b exp 1", irq); end
    if (sclk !== cur_cpol) begin errors++; $display("FAIL xfer_sclk_idle got %b exp %b", sclk, cur_cpol); end
    if (mosi !== tx[0])    begin errors++; $display("FAIL xfer_mosi_hold got %b exp %b", mosi, tx[0]); end
    peek(2'd0, v);
    if (v !== exp_rx)      begin errors++; $display("FAIL xfer_rx got %h exp %h", v, exp_rx); end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    checks += 9;
    if (cs_n !== 4'hF) begin errors++; $display("FAIL rst_cs_n got %b exp 1111", cs_n); end
    if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", sclk); end
    if (mosi !== 1'b1) begin errors++; $display("FAIL rst_mosi got %b exp 1", mosi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (irq !== 1'b0)  begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    peek(2'd1, v);
    if (v !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %h exp 00", v); end
    peek(2'd3, v);
    if (v !== 8'h3F) begin errors++; $display("FAIL rst_div got %h exp 3f", v); end
    peek(2'd0, v);
    if (v !== 8'hFF) begin errors++; $display("FAIL rst_data got %h exp ff", v); end
    peek(2'd2, v);
    if (v !== 8'h00) begin errors++; $display("FAIL rst_cs got %h exp 00", v); end
  endtask

  task automatic test_loopback();
    wr(2'd3, 8'd0);
    do_xfer(8'hA5, 8'h00, 1'b1, -1);
    rd_data();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL loop_irq_clear got %b exp 0", irq); end
  endtask

  task automatic test_mode3();
    logic [7:0] v;
    wr(2'd3, 8'd3);
    wr(2'd1, 8'h03);
    checks += 2;
    peek(2'd1, v);
    if (v !== exp_ctrl(1'b0)) begin errors++; $display("FAIL mode3_ctrl got %h exp %h", v, exp_ctrl(1'b0)); end
    if (sclk !== cur_cpol)    begin errors++; $display("FAIL mode3_sclk_idle got %b exp %b", sclk, cur_cpol); end
    do_xfer(8'h3C, 8'h00, 1'b0, -1);
    wr(2'd1, 8'h40);
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int i = 0; i < 6; i++) begin
      wr(2'd3, 8'($urandom_range(0, 4)));
      wr(2'd1, 8'($urandom_range(0, 3)));
      do_xfer(8'($urandom), 8'($urandom), 1'($urandom), -1);
      checks++;
      peek(2'd1, v);
      if (v !== exp_ctrl(1'b0)) begin errors++; $display("FAIL rand_ctrl got %h exp %h", v, exp_ctrl(1'b0)); end
    end
    wr(2'd1, 8'h40);
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    wr(2'd3, 8'd1);
    do_xfer(8'h11, 8'h00, 1'b1, 5);
    checks += 3;
    peek(2'd1, v);
    if (v !== exp_ctrl(1'b0)) begin errors++; $display("FAIL ovr_ctrl got %h exp %h", v, exp_ctrl(1'b0)); end
    if (v[6] !== 1'b1)        begin errors++; $display("FAIL ovr_bit got %b exp 1", v[6]); end
    wr(2'd1, 8'h40);
    peek(2'd1, v);
    if (v !== 8'h00) begin errors++; $display("FAIL ovr_clear got %h exp 00", v); end
  endtask

  task automatic test_back_to_back();
    wr(2'd3, 8'd0);
    do_xfer(8'h5A, 8'h00, 1'b1, -1);
    do_xfer(8'hC3, 8'h96, 1'b0, -1);
  endtask

  task automatic test_cs_and_hold();
    logic [7:0] v, tx;
    int cyc, rises;
    logic prev;
    wr(2'd2, 8'hF5);
    checks += 2;
    if (cs_n !== 4'b1010) begin errors++; $display("FAIL cs_n got %b exp 1010", cs_n); end
    peek(2'd2, v);
    if (v !== 8'h05) begin errors++; $display("FAIL cs_read got %h exp 05", v); end
    wr(2'd3, 8'd0);
    tx = 8'($urandom);
    iaddr = 2'd0; idata = tx; iwe_n = 1'b0;
    cyc = 0; rises = 0; prev = 1'b0;
    repeat (30) begin
      step();
      if (busy) cyc++;
      if (busy && !prev) rises++;
      prev = busy;
    end
    iwe_n = 1'b1;
    step();
    m_done = 1'b1; last_mosi = tx[0];
    checks += 4;
    if (cyc !== 16)  begin errors++; $display("FAIL hold_busy_cycles got %0d exp 16", cyc); end
    if (rises !== 1) begin errors++; $display("FAIL hold_starts got %0d exp 1", rises); end
    peek(2'd1, v);
    if (v !== exp_ctrl(1'b0)) begin errors++; $display("FAIL hold_ctrl got %h exp %h", v, exp_ctrl(1'b0)); end
    if (mosi !== tx[0]) begin errors++; $display("FAIL hold_mosi got %b exp %b", mosi, tx[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    wr(2'd1, 8'h40);
    wr(2'd3, 8'd3);
    wr(2'd2, 8'h05);
    iaddr = 2'd0; idata = 8'h81; iwe_n = 1'b0;
    step();
    iwe_n = 1'b1;
    repeat (28) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    if (sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk got %b exp 0", sclk); end
    if (mosi !== 1'b1) begin errors++; $display("FAIL mid_mosi got %b exp 1", mosi); end
    if (cs_n !== 4'hF) begin errors++; $display("FAIL mid_cs_n got %b exp 1111", cs_n); end
    if (irq !== 1'b0)  begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step();
    checks++;
    peek(2'd3, v);
    if (v !== 8'h3F) begin errors++; $display("FAIL mid_div_reset got %h exp 3f", v); end
    wr(2'd3, 8'd2);
    do_xfer(8'($urandom), 8'($urandom), 1'b0, -1);
  endtask

  initial begin
    reset_n = 1'b0; iaddr = 2'd0; idata = 8'h00;
    iwe_n = 1'b1; ird_n = 1'b1; miso = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    step();
    test_reset();
    test_loopback();
    test_mode3();
    test_overrun();
    test_back_to_back();
    test_cs_and_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
